mem_subsystem: RTL and testbench
================================

Name: mem_subsystem

Overview:
- Parametrised data-memory subsystem for the ARM datapath: byte-addressed RAM with byte/halfword/word access, instruction-register load port and a second read-only display port.
- Memory-mapped keyboard receive FIFO and status register replace the single-byte key latch, so keystrokes are buffered instead of lost.
- Sits between the control unit/datapath and the keyboard and display front-ends.

Parameters:
- ADDR_W, 18, byte-address width; RAM depth = 2^(ADDR_W-2) 32-bit words.
- KBD_DATA_ADDR, 18'h3FFF0, byte address of the keyboard data register (pop on read).
- KBD_STAT_ADDR, 18'h3FFF4, byte address of the keyboard status register.
- KBD_DEPTH, 8, keyboard FIFO entries; power of two, 2..16.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- isWrite  in  1  write strobe for the datapath port.
- isRead  in  1  read strobe for the datapath port; required for the FIFO pop side effect.
- accSize  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- address  in  ADDR_W  datapath byte address.
- writeData  in  32  write data, right-justified for byte/halfword.
- data  out  32  registered read data, zero-extended.
- IRWrite  in  1  loads IR from the word at address[ADDR_W-1:2].
- IR  out  32  instruction register.
- displayAddr  in  ADDR_W  display port byte address, word-granular.
- displayData  out  32  registered display read data.
- sample  in  1  keyboard strobe, synchronous to clock.
- key_reg  in  8  key code, valid while sample is high.
- accErr  out  1  one-cycle pulse on a misaligned or reserved-size access.

Behaviour:
- Reset: data, IR, displayData and accErr are 0; FIFO is empty; overflow is 0; the sample edge detector is cleared. RAM contents are not reset.
- Byte lanes are little-endian: byte k (address[1:0]=k) occupies bits 8k+7:8k.
- Write (isWrite=1):
  - Byte writes writeData[7:0] to the addressed lane.
  - Halfword writes writeData[15:0] to lanes {a1,0}+1:{a1,0}.
  - Word writes all four lanes.
  - Unaddressed lanes are unchanged. Writes take effect at the edge.
- Read (isRead=1): data is updated at the next edge (1-cycle latency). The selected byte or halfword is zero-extended. When isRead=0, data holds its value.
- Read-after-write to the same address on consecutive cycles returns the new value. With isWrite and isRead in the same cycle, the write wins and data returns the old contents.
- Misaligned access: halfword with address[0]=1, word with address[1:0]!=0, or accSize=11.
  - The access is suppressed: no write, data unchanged, no FIFO pop.
  - accErr=1 for exactly one cycle.
- IRWrite=1: IR <= mem[address[ADDR_W-1:2]] at the edge (1-cycle latency), independent of isRead. IR otherwise holds.
- Display port: displayData <= mem[displayAddr[ADDR_W-1:2]] every cycle (1-cycle latency), with no side effects.
- Keyboard FIFO push: a rising edge of sample (sample=1, previous=0) pushes key_reg. Holding sample high pushes only once.
- Full FIFO on push: the key is dropped, the overflow sticky bit is set and contents are unchanged.
- Pop: a byte read of KBD_DATA_ADDR with isRead=1 sets data = {24'b0, head} and pops the head.
- Empty FIFO on pop: data = 0 and the pointers are unchanged.
- Simultaneous push and pop:
  - Non-empty: both occur and count is unchanged.
  - Empty: the pop returns 0 and the pushed key is stored (count=1).
  - Full: the pop frees a slot, the push is accepted and overflow is not set.
- KBD_STAT read (any size) returns: bit0 not-empty, bit1 full, bit2 overflow, bits[8+4:8] count, all other bits 0.
- KBD_STAT write (any data) clears overflow.
- RAM writes to KBD_DATA_ADDR or KBD_STAT_ADDR do not modify RAM. Non-byte reads of KBD_DATA_ADDR return 0 with no pop.
- Pointers wrap modulo KBD_DEPTH. Count spans 0..KBD_DEPTH.
- Reset asserted mid-operation empties the FIFO immediately. Any in-flight write is lost if reset is asserted at that edge.

Optional Feature:
- Macro KBD_IRQ_EN.
- When defined: adds output kbdIrq (1 bit). kbdIrq is registered, reset to 0, and is 1 whenever the FIFO is non-empty or overflow=1.
- When not defined: no kbdIrq port. Software polls KBD_STAT.

Test Plan:
- Word write 32'h12345678 at 18'h02368, then word read at the same address -> data=32'h12345678 one cycle after the read strobe.
- Byte write 8'h87 at 18'h0236B, then word read at 18'h02368 -> 32'h87345678; byte read at 18'h0236B -> 32'h00000087.
- Halfword write at 18'h02369 -> no RAM change and accErr high for exactly 1 cycle. IRWrite at 18'h02368 -> IR=32'h87345678; displayAddr=18'h02368 -> displayData matches.
- Push keys 8'h12, 8'h34 via sample pulses, then 2 pops plus a third pop -> data 8'h12, 8'h34, then 0. KBD_STAT reads 0 after the pops.
- Push 9 keys with KBD_DEPTH=8 -> KBD_STAT=32'h00000807 (count 8, overflow, full, not-empty). Write KBD_STAT -> overflow clears. Pop and push in the same cycle -> count stays 8.
- Assert reset with 3 keys queued -> FIFO empty, data/IR/displayData=0. With KBD_IRQ_EN defined, kbdIrq goes 1 after the first push and 0 after reset.

Source files
------------

// File: rtl/mem_subsystem_if.sv
// mem_subsystem_if
// Bus bundle between the datapath/control unit and the data-memory subsystem.
// Carries the datapath access port, the IR load strobe, the display read port
// and the keyboard strobe/key code, plus the responses from the memory.
//   master : control unit / datapath side (drives requests, receives data)
//   slave  : mem_subsystem side (receives requests, drives data)
interface mem_subsystem_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              isWrite;
  logic              isRead;
  logic [1:0]        accSize;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writeData;
  logic [31:0]       data;
  logic              IRWrite;
  logic [31:0]       IR;
  logic [ADDR_W-1:0] displayAddr;
  logic [31:0]       displayData;
  logic              sample;
  logic [7:0]        key_reg;
  logic              accErr;

  modport master (
    output isWrite, isRead, accSize, address, writeData, IRWrite,
           displayAddr, sample, key_reg,
    input  data, IR, displayData, accErr
  );

  modport slave (
    input  isWrite, isRead, accSize, address, writeData, IRWrite,
           displayAddr, sample, key_reg,
    output data, IR, displayData, accErr
  );
endinterface

// File: rtl/mem_subsystem.sv
// mem_subsystem
// Byte-addressed data RAM (byte/halfword/word, little-endian lanes) with a
// registered datapath read port, an instruction-register load port and a
// read-only display port. Two memory-mapped registers front a keyboard FIFO:
// KBD_DATA_ADDR (byte read pops the head) and KBD_STAT_ADDR (status on read,
// any write clears the overflow flag).
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : mem_subsystem_if.slave (access port, IR, display, keyboard)
//   kbdIrq       : registered "FIFO non-empty or overflow" request, present
//                  only when the macro KBD_IRQ_EN is defined
module mem_subsystem #(
  parameter int unsigned       ADDR_W        = 18,
  parameter logic [ADDR_W-1:0] KBD_DATA_ADDR = ADDR_W'(18'h3FFF0),
  parameter logic [ADDR_W-1:0] KBD_STAT_ADDR = ADDR_W'(18'h3FFF4),
  parameter int unsigned       KBD_DEPTH     = 8
) (
  input  logic clock,
  input  logic reset,
  mem_subsystem_if.slave bus
`ifdef KBD_IRQ_EN
  ,
  output logic kbdIrq
`endif
);

  localparam int unsigned WORDS    = 1 << (ADDR_W - 2);
  localparam int unsigned PTR_W    = $clog2(KBD_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(KBD_DEPTH);

  logic [31:0] mem [WORDS];
  logic [7:0]  fifo [KBD_DEPTH];

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             samplePrev_q;
  logic [31:0]      data_q, data_d, ir_q, ir_d, disp_q, disp_d;
  logic             accErr_q, accErr_d;

  logic              misaligned, isKbdData, isKbdStat;
  logic              ramWrite, statWrite, popReq, doPop, doPush, sampleRise;
  logic              fifoEmpty, fifoFull;
  logic [ADDR_W-3:0] wordIdx;
  logic [31:0]       wordRd, shifted, ramRdVal, statusWord, wrLanes;
  logic [3:0]        byteEn;
  logic              unusedDispBits;

  assign wordIdx        = bus.address[ADDR_W-1:2];
  assign wordRd         = mem[wordIdx];
  assign unusedDispBits = ^bus.displayAddr[1:0];
  assign isKbdData      = (bus.address == KBD_DATA_ADDR);
  assign isKbdStat      = (bus.address == KBD_STAT_ADDR);
  assign fifoEmpty      = (count_q == '0);
  assign fifoFull       = (count_q == FULL_CNT);
  assign statusWord     = {19'b0, 5'(count_q), 5'b0, ovf_q, fifoFull, ~fifoEmpty};

  // Size decode: alignment check, lane enables and write data replicated onto
  // every lane so the enabled lane(s) pick up the right-justified value.
  always_comb begin
    misaligned = 1'b0;
    byteEn     = 4'b0000;
    wrLanes    = bus.writeData;
    case (bus.accSize)
      2'b00: begin
        byteEn  = 4'b0001 << bus.address[1:0];
        wrLanes = {4{bus.writeData[7:0]}};
      end
      2'b01: begin
        misaligned = bus.address[0];
        byteEn     = bus.address[1] ? 4'b1100 : 4'b0011;
        wrLanes    = {2{bus.writeData[15:0]}};
      end
      2'b10: begin
        misaligned = (bus.address[1:0] != 2'b00);
        byteEn     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Read lane extraction: shift the addressed lane down and zero-extend.
  always_comb begin
    shifted = wordRd >> {bus.address[1:0], 3'b000};
    case (bus.accSize)
      2'b00:   ramRdVal = {24'b0, shifted[7:0]};
      2'b01:   ramRdVal = {16'b0, shifted[15:0]};
      default: ramRdVal = wordRd;
    endcase
  end

  // Access qualification. A pop on an empty FIFO leaves pointers alone, and a
  // push into a full FIFO is only accepted when a pop frees a slot this cycle.
  assign ramWrite   = bus.isWrite & ~misaligned & ~isKbdData & ~isKbdStat;
  assign statWrite  = bus.isWrite & ~misaligned & isKbdStat;
  assign sampleRise = bus.sample & ~samplePrev_q;
  assign popReq     = bus.isRead & ~misaligned & isKbdData & (bus.accSize == 2'b00);
  assign doPop      = popReq & ~fifoEmpty;
  assign doPush     = sampleRise & (~fifoFull | doPop);

  // Next-state for FIFO bookkeeping and the registered outputs.
  always_comb begin
    rdPtr_d  = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
    wrPtr_d  = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    count_d  = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    ovf_d    = ovf_q;
    data_d   = data_q;
    accErr_d = (bus.isRead | bus.isWrite) & misaligned;
    ir_d     = bus.IRWrite ? wordRd : ir_q;
    disp_d   = mem[bus.displayAddr[ADDR_W-1:2]];
    if (statWrite) begin
      ovf_d = 1'b0;
    end
    if (sampleRise && fifoFull && !doPop) begin
      ovf_d = 1'b1;
    end
    if (bus.isRead && !misaligned) begin
      if (isKbdData) begin
        data_d = (popReq && !fifoEmpty) ? {24'b0, fifo[rdPtr_q]} : 32'b0;
      end else if (isKbdStat) begin
        data_d = statusWord;
      end else begin
        data_d = ramRdVal;
      end
    end
  end

  // State update. RAM and FIFO storage are not cleared, but sit in the reset
  // branch's else so a write coinciding with reset is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      samplePrev_q <= 1'b0;
      data_q       <= '0;
      ir_q         <= '0;
      disp_q       <= '0;
      accErr_q     <= 1'b0;
    end else begin
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      samplePrev_q <= bus.sample;
      data_q       <= data_d;
      ir_q         <= ir_d;
      disp_q       <= disp_d;
      accErr_q     <= accErr_d;
      if (ramWrite && byteEn[0]) mem[wordIdx][7:0]   <= wrLanes[7:0];
      if (ramWrite && byteEn[1]) mem[wordIdx][15:8]  <= wrLanes[15:8];
      if (ramWrite && byteEn[2]) mem[wordIdx][23:16] <= wrLanes[23:16];
      if (ramWrite && byteEn[3]) mem[wordIdx][31:24] <= wrLanes[31:24];
      if (doPush) fifo[wrPtr_q] <= bus.key_reg;
    end
  end

  assign bus.data        = data_q;
  assign bus.IR          = ir_q;
  assign bus.displayData = disp_q;
  assign bus.accErr      = accErr_q;

`ifdef KBD_IRQ_EN
  logic kbdIrq_q;

  // Interrupt request tracks the post-update FIFO state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kbdIrq_q <= 1'b0;
    end else begin
      kbdIrq_q <= (count_d != '0) | ovf_d;
    end
  end

  assign kbdIrq = kbdIrq_q;
`endif

endmodule

// File: tb/tb_mem_subsystem.sv
// tb_mem_subsystem
// Self-checking bench for mem_subsystem: directed scenarios followed by
// randomized RAM and keyboard traffic, checked against a byte-array memory
// model and a queue-based keyboard FIFO model.
module tb_mem_subsystem;
  localparam int ADDR_W = 18;
  localparam logic [17:0] KBD_DATA = 18'h3FFF0;
  localparam logic [17:0] KBD_STAT = 18'h3FFF4;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_subsystem_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef KBD_IRQ_EN
  logic kbdIrq;
`endif

  mem_subsystem #(
    .ADDR_W(ADDR_W),
    .KBD_DATA_ADDR(18'h3FFF0),
    .KBD_STAT_ADDR(18'h3FFF4),
    .KBD_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef KBD_IRQ_EN
    ,
    .kbdIrq(kbdIrq)
`endif
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [7:0]  modelMem [int];
  logic [7:0]  modelFifo [$];
  bit          modelOvf;
  logic [31:0] expData;

  function automatic bit isMisaligned(input logic [1:0] size, input logic [17:0] addr);
    return (size == 2'd3) || ((int'(addr) % (1 << size)) != 0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [17:0] addr, input logic [1:0] size);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < (1 << size); i++) v[8*i +: 8] = modelMem[int'(addr) + i];
    return v;
  endfunction

  function automatic void modelWrite(input logic [17:0] addr, input logic [1:0] size,
                                     input logic [31:0] wd);
    for (int i = 0; i < (1 << size); i++) modelMem[int'(addr) + i] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] modelStatus();
    int n;
    n = modelFifo.size();
    return 32'((n << 8) | (modelOvf ? 4 : 0) | ((n == DEPTH) ? 2 : 0) | ((n != 0) ? 1 : 0));
  endfunction

  function automatic logic [31:0] modelPop();
    if (modelFifo.size() == 0) return 32'd0;
    return {24'b0, modelFifo.pop_front()};
  endfunction

  function automatic void modelPush(input logic [7:0] key);
    if (modelFifo.size() < DEPTH) modelFifo.push_back(key);
    else modelOvf = 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] size,
                               input logic [17:0] addr, input logic [31:0] wd,
                               input logic irw, input logic samp, input logic [7:0] key);
    bus.isWrite   = w;
    bus.isRead    = r;
    bus.accSize   = size;
    bus.address   = addr;
    bus.writeData = wd;
    bus.IRWrite   = irw;
    bus.sample    = samp;
    bus.key_reg   = key;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'd0, 18'd0, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic memOp(input logic w, input logic r, input logic [1:0] size,
                       input logic [17:0] addr, input logic [31:0] wd, input string tag);
    bit          mis;
    logic [31:0] rdVal;
    mis   = isMisaligned(size, addr);
    rdVal = '0;
    if (r && !mis) rdVal = modelRead(addr, size);
    if (w && !mis) modelWrite(addr, size, wd);
    applyStimulus(w, r, size, addr, wd, 1'b0, 1'b0, 8'd0);
    if (r && !mis) expData = rdVal;
    checkOutput({tag, "_data"}, bus.data, expData);
    checkOutput({tag, "_accErr"}, {31'b0, bus.accErr}, {31'b0, (w || r) && mis});
  endtask

  task automatic kbdPush(input logic [7:0] key);
    modelPush(key);
    applyStimulus(1'b0, 1'b0, 2'd0, 18'd0, 32'd0, 1'b0, 1'b1, key);
    idle();
  endtask

  task automatic kbdPop(input string tag);
    expData = modelPop();
    applyStimulus(1'b0, 1'b1, 2'd0, KBD_DATA, 32'd0, 1'b0, 1'b0, 8'd0);
    checkOutput(tag, bus.data, expData);
  endtask

  task automatic statRead(input string tag);
    expData = modelStatus();
    applyStimulus(1'b0, 1'b1, 2'd2, KBD_STAT, 32'd0, 1'b0, 1'b0, 8'd0);
    checkOutput(tag, bus.data, expData);
  endtask

  initial begin
    logic [17:0] base [4];
    logic [17:0] a;
    logic [1:0]  sz;
    int          op;
    int          k;

    bus.isWrite     = 1'b0;
    bus.isRead      = 1'b0;
    bus.accSize     = 2'd0;
    bus.address     = '0;
    bus.writeData   = '0;
    bus.IRWrite     = 1'b0;
    bus.displayAddr = '0;
    bus.sample      = 1'b0;
    bus.key_reg     = '0;
    modelOvf        = 1'b0;
    expData         = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_data", bus.data, 32'd0);
    checkOutput("rst_IR", bus.IR, 32'd0);
    checkOutput("rst_disp", bus.displayData, 32'd0);
    checkOutput("rst_accErr", {31'b0, bus.accErr}, 32'd0);
    reset = 1'b0;

    // Word write/read, byte lane merge, halfword read
    memOp(1'b1, 1'b0, 2'd2, 18'h02368, 32'h12345678, "wr_word");
    memOp(1'b0, 1'b1, 2'd2, 18'h02368, 32'd0, "rd_word");
    checkOutput("tp_word", bus.data, 32'h12345678);
    memOp(1'b1, 1'b0, 2'd0, 18'h0236B, 32'h00000087, "wr_byte");
    memOp(1'b0, 1'b1, 2'd2, 18'h02368, 32'd0, "rd_merged");
    checkOutput("tp_merged", bus.data, 32'h87345678);
    memOp(1'b0, 1'b1, 2'd0, 18'h0236B, 32'd0, "rd_byte");
    checkOutput("tp_byte", bus.data, 32'h00000087);
    memOp(1'b0, 1'b1, 2'd1, 18'h0236A, 32'd0, "rd_half");

    // Misaligned accesses are suppressed and pulse accErr once
    memOp(1'b1, 1'b0, 2'd1, 18'h02369, 32'h0000BEEF, "wr_mis_half");
    idle();
    checkOutput("accErr_pulse_end", {31'b0, bus.accErr}, 32'd0);
    memOp(1'b0, 1'b1, 2'd2, 18'h02368, 32'd0, "rd_after_mis");
    checkOutput("tp_nochange", bus.data, 32'h87345678);
    memOp(1'b0, 1'b1, 2'd1, 18'h02369, 32'd0, "rd_mis_half");
    memOp(1'b0, 1'b1, 2'd3, 18'h02368, 32'd0, "rd_reserved");

    // IR load and display port
    bus.displayAddr = 18'h02368;
    applyStimulus(1'b0, 1'b0, 2'd2, 18'h02368, 32'd0, 1'b1, 1'b0, 8'd0);
    checkOutput("ir_load", bus.IR, 32'h87345678);
    checkOutput("disp_rd", bus.displayData, 32'h87345678);

    // Write and read in the same cycle: read returns the old word
    memOp(1'b1, 1'b1, 2'd2, 18'h02368, 32'hAAAAAAAA, "wr_rd_same");
    checkOutput("ir_hold", bus.IR, 32'h87345678);
    memOp(1'b0, 1'b1, 2'd2, 18'h02368, 32'd0, "rd_new");
    checkOutput("disp_new", bus.displayData, 32'hAAAAAAAA);

    // Keyboard: edge-triggered push, non-byte data read, pops
    kbdPush(8'h12);
`ifdef KBD_IRQ_EN
    checkOutput("irq_push", {31'b0, kbdIrq}, 32'd1);
`endif
    modelPush(8'h34);
    applyStimulus(1'b0, 1'b0, 2'd0, 18'd0, 32'd0, 1'b0, 1'b1, 8'h34);
    applyStimulus(1'b0, 1'b0, 2'd0, 18'd0, 32'd0, 1'b0, 1'b1, 8'h56);
    idle();
    expData = 32'd0;
    applyStimulus(1'b0, 1'b1, 2'd2, KBD_DATA, 32'd0, 1'b0, 1'b0, 8'd0);
    checkOutput("kbd_word_rd", bus.data, expData);
    statRead("stat_two");
    kbdPop("pop1");
    checkOutput("tp_pop1", bus.data, 32'h12);
    kbdPop("pop2");
    checkOutput("tp_pop2", bus.data, 32'h34);
    kbdPop("pop_empty");
    statRead("stat_empty");
    checkOutput("tp_stat_empty", bus.data, 32'd0);

    // Overflow, status write clears it, pop+push at full
    for (int i = 0; i < 9; i++) kbdPush(8'h40 + 8'(i));
    statRead("stat_ovf");
    checkOutput("tp_stat_ovf", bus.data, 32'h00000807);
    modelOvf = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd2, KBD_STAT, $urandom, 1'b0, 1'b0, 8'd0);
    statRead("stat_clr");
    expData = modelPop();
    modelPush(8'hA5);
    applyStimulus(1'b0, 1'b1, 2'd0, KBD_DATA, 32'd0, 1'b0, 1'b1, 8'hA5);
    checkOutput("poppush_full", bus.data, expData);
    idle();
    statRead("stat_poppush");
    checkOutput("tp_count8", bus.data, 32'h00000803);
    for (int i = 0; i < DEPTH; i++) kbdPop("drain");

    // Pop+push on empty: pop returns 0, key is stored
    expData = modelPop();
    modelPush(8'h5A);
    applyStimulus(1'b0, 1'b1, 2'd0, KBD_DATA, 32'd0, 1'b0, 1'b1, 8'h5A);
    checkOutput("poppush_empty", bus.data, expData);
    idle();
    statRead("stat_one");

    // Reset with three keys queued
    kbdPush(8'h01);
    kbdPush(8'h02);
    reset = 1'b1;
    #2;
    checkOutput("mrst_data", bus.data, 32'd0);
    checkOutput("mrst_IR", bus.IR, 32'd0);
    checkOutput("mrst_disp", bus.displayData, 32'd0);
`ifdef KBD_IRQ_EN
    checkOutput("irq_rst", {31'b0, kbdIrq}, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelFifo.delete();
    modelOvf = 1'b0;
    expData  = 32'd0;
    statRead("stat_after_rst");

    // Randomized RAM traffic over a few initialized words
    for (int i = 0; i < 4; i++) begin
      base[i] = 18'($urandom_range(0, 32'h3F00) << 2);
      memOp(1'b1, 1'b0, 2'd2, base[i], $urandom, "rnd_init");
    end
    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 3);
      a  = base[k] + 18'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      memOp(op != 1, op != 0, sz, a, $urandom, "rnd_mem");
    end

    // Randomized keyboard traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) kbdPush(8'($urandom));
      else kbdPop("rnd_pop");
      if ((i % 8) == 7) statRead("rnd_stat");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
